// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, master IDs and bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Master IDs; a single bit is enough to name the winner.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way request picker.
//               Ports: req[1:0]   - request vector (bit n = master n)
//                      last_grant - master that won the previous grant
//                      winner     - selected master ID
//                      valid      - at least one request present
//               FIXED_PRIO=1 makes master 0 win every tie; otherwise a tie
//               goes to the master that is not last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b11) begin
      winner = (FIXED_PRIO != 0) ? M0 : ~last_grant;
    end else if (req[1]) begin
      winner = M1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter/sequencer in front of a single-port,
//               word-addressed data memory. One transaction at a time:
//               IDLE (arbitrate, latch) -> ACCESS (gnt, drive memory)
//               -> RESP (rvalid, err). All outputs are registered.
//               Ports: clk, rst (async active-low)
//                      m{0,1}_req/we/addr/wdata      - master requests
//                      m{0,1}_gnt/rvalid/rdata/err   - master responses
//                      mem_ena/addr/wdata, mem_rdata - memory interface
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_ena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   cur_we;
  logic   cur_in_range;

  logic              pick_id;
  logic              pick_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .winner     (pick_id),
    .valid      (pick_valid)
  );

  always_comb begin
    sel_we       = (pick_id == M1) ? m1_we    : m0_we;
    sel_addr     = (pick_id == M1) ? m1_addr  : m0_addr;
    sel_wdata    = (pick_id == M1) ? m1_wdata : m0_wdata;
    // Full-width compare: upper address bits only matter here.
    sel_in_range = (sel_addr < DEPTH_A);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= M1;  // so master 0 wins the first tie
      cur_id       <= M0;
      cur_we       <= 1'b0;
      cur_in_range <= 1'b0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_ena      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      mem_ena   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state        <= ACCESS;
            cur_id       <= pick_id;
            last_grant   <= pick_id;
            cur_we       <= sel_we;
            cur_in_range <= sel_in_range;
            // mem_addr/mem_wdata double as the latched request.
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            mem_ena      <= sel_we & sel_in_range;
            if (pick_id == M1) m1_gnt <= 1'b1;
            else               m0_gnt <= 1'b1;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (cur_id == M1) begin
            m1_rvalid <= 1'b1;
            m1_err    <= ~cur_in_range;
            if (!cur_in_range)  m1_rdata <= '0;
            else if (!cur_we)   m1_rdata <= mem_rdata;
          end else begin
            m0_rvalid <= 1'b1;
            m0_err    <= ~cur_in_range;
            if (!cur_in_range)  m0_rdata <= '0;
            else if (!cur_we)   m0_rdata <= mem_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter. Two instances
//               share the master stimulus: dut (round-robin) and dut_fp
//               (fixed priority), each with its own memory array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_ena;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        f0_gnt, f0_rvalid, f0_err, f1_gnt, f1_rvalid, f1_err, fmem_ena;
  logic [31:0] f0_rdata, f1_rdata, fmem_addr, fmem_wdata, fmem_rdata;

  logic [31:0] mem  [0:1023];
  logic [31:0] fmem [0:1023];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.DEPTH(1024), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_ena(mem_ena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DEPTH(1024), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata), .m0_err(f0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata), .m1_err(f1_err),
    .mem_ena(fmem_ena), .mem_addr(fmem_addr), .mem_wdata(fmem_wdata),
    .mem_rdata(fmem_rdata)
  );

  // Memory models: combinational read, write on rising edge.
  assign mem_rdata  = mem[mem_addr[9:0]];
  assign fmem_rdata = fmem[fmem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_ena)  mem[mem_addr[9:0]]   <= mem_wdata;
    if (fmem_ena) fmem[fmem_addr[9:0]] <= fmem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_ena} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_ena});
    end
    checks++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               m0_rdata, m1_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'd6;
    tick();  // acceptance edge
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_ena !== 1'b0 || mem_addr !== 32'd6) begin
      errors++;
      $display("FAIL read_gnt: gnt0=%b gnt1=%b ena=%b addr=%0d want 1 0 0 6",
               m0_gnt, m1_gnt, mem_ena, mem_addr);
    end
    m0_req = 0;
    tick();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'd45 || m0_err !== 1'b0 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: rvalid=%b rdata=%0d err=%b gnt=%b want 1 45 0 0",
               m0_rvalid, m0_rdata, m0_err, m0_gnt);
    end
    tick();
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'd45) begin
      errors++;
      $display("FAIL read_hold: rvalid=%b rdata=%0d want 0 45", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_write_read();
    int ena_cycles;
    ena_cycles = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'd5; m1_wdata = 32'hDEADBEEF;
    tick();
    if (mem_ena) ena_cycles++;
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'd5) begin
      errors++;
      $display("FAIL wr_gnt: gnt1=%b gnt0=%b wdata=%h addr=%0d want 1 0 deadbeef 5",
               m1_gnt, m0_gnt, mem_wdata, mem_addr);
    end
    m1_req = 0;
    tick();
    if (mem_ena) ena_cycles++;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL wr_resp: rvalid=%b err=%b rdata=%h want 1 0 00000000",
               m1_rvalid, m1_err, m1_rdata);
    end
    tick();
    if (mem_ena) ena_cycles++;
    checks++;
    if (ena_cycles != 1 || mem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_mem: ena_cycles=%0d mem5=%h want 1 deadbeef", ena_cycles, mem[5]);
    end
    m1_req = 1; m1_we = 0; m1_addr = 32'd5;
    tick();
    m1_req = 0;
    tick();
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_readback: rvalid=%b rdata=%h err=%b want 1 deadbeef 0",
               m1_rvalid, m1_rdata, m1_err);
    end
    tick();
  endtask

  task automatic test_contention();
    logic want_m1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m0_req = 1; m0_we = 0; m0_addr = 32'd6;
    m1_req = 1; m1_we = 0; m1_addr = 32'd5;
    for (int k = 0; k < 4; k++) begin
      want_m1 = (k % 2) == 1;
      tick();
      checks++;
      if (m0_gnt !== ~want_m1 || m1_gnt !== want_m1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt0=%b gnt1=%b want %b %b",
                 k, m0_gnt, m1_gnt, ~want_m1, want_m1);
      end
      checks++;
      if (f0_gnt !== 1'b1 || f1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fp_grant%0d: gnt0=%b gnt1=%b want 1 0", k, f0_gnt, f1_gnt);
      end
      tick();
      checks++;
      if (m0_gnt | m1_gnt | f0_gnt | f1_gnt || m0_rvalid !== ~want_m1 || m1_rvalid !== want_m1) begin
        errors++;
        $display("FAIL rr_resp%0d: gnts=%b%b%b%b rv0=%b rv1=%b want 0000 %b %b",
                 k, m0_gnt, m1_gnt, f0_gnt, f1_gnt, m0_rvalid, m1_rvalid, ~want_m1, want_m1);
      end
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end
      tick();
      checks++;
      if (m0_gnt | m1_gnt | f0_gnt | f1_gnt) begin
        errors++;
        $display("FAIL rr_gap%0d: gnts=%b%b%b%b want 0000", k, m0_gnt, m1_gnt, f0_gnt, f1_gnt);
      end
    end
  endtask

  task automatic test_out_of_range();
    m0_req = 1; m0_we = 1; m0_addr = 32'd1024; m0_wdata = 32'h12345678;
    tick();
    checks++;
    if (m0_gnt !== 1'b1 || mem_ena !== 1'b0) begin
      errors++;
      $display("FAIL oor_gnt: gnt=%b ena=%b want 1 0", m0_gnt, mem_ena);
    end
    m0_req = 0;
    tick();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'd0 || mem_ena !== 1'b0) begin
      errors++;
      $display("FAIL oor_resp: rvalid=%b err=%b rdata=%h ena=%b want 1 1 00000000 0",
               m0_rvalid, m0_err, m0_rdata, mem_ena);
    end
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'd0;
    tick();
    m0_req = 0;
    tick();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'd0 || mem[0] !== 32'd0) begin
      errors++;
      $display("FAIL oor_read0: rvalid=%b err=%b rdata=%h mem0=%h want 1 0 0 0",
               m0_rvalid, m0_err, m0_rdata, mem[0]);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int stray;
    stray = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'd2; m0_wdata = 32'd7;
    tick();
    checks++;
    if (mem_ena !== 1'b1 || m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_access: ena=%b gnt=%b want 1 1", mem_ena, m0_gnt);
    end
    m0_req = 0;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_ena !== 1'b0 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: ena=%b gnt=%b want 0 0", mem_ena, m0_gnt);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (m0_rvalid | m1_rvalid) stray++;
      tick();
    end
    checks++;
    if (mem[2] !== 32'd3 || stray != 0) begin
      errors++;
      $display("FAIL mid_nowrite: mem2=%0d stray_rvalid=%0d want 3 0", mem[2], stray);
    end
    m0_req = 1; m0_we = 0; m0_addr = 32'd2;
    m1_req = 1; m1_we = 0; m1_addr = 32'd5;
    tick();
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL mid_tie: gnt0=%b gnt1=%b want 1 0", m0_gnt, m1_gnt);
    end
    m0_req = 0; m1_req = 0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'd0;
      fmem[i] = 32'd0;
    end
    mem[6]  = 32'd45; fmem[6] = 32'd45;
    mem[2]  = 32'd3;  fmem[2] = 32'd3;
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case of a stuck clock or schedule.
  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port, word-addressed data memory.
- Master 0 is the core load/store unit. Master 1 is the debug/DMA loader port.
- Accepts one request at a time using a req/gnt handshake.
- Drives the memory's enable, address and write-data inputs for exactly one cycle per transaction.
- Registers the read data and returns it with a one-cycle rvalid pulse. Out-of-range addresses are rejected with an error response.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; valid addresses are 0..DEPTH-1.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  32  master 0 word address.
- m0_wdata  input  32  master 0 write data.
- m0_gnt  output  1  master 0 grant pulse.
- m0_rvalid  output  1  master 0 response pulse (reads and writes).
- m0_rdata  output  32  master 0 read data.
- m0_err  output  1  master 0 error, qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same widths and meanings for master 1.
- mem_ena  output  1  memory write enable; memory reads whenever this is 0.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All gnt, rvalid, err and mem_ena outputs go to 0.
  - All rdata, mem_addr and mem_wdata outputs go to 0.
  - last_grant is set to 1, so master 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP. Transitions are IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always.
- Arbitration happens in IDLE only:
  - Single requester: that requester wins.
  - Both requesting with FIXED_PRIO=1: master 0 wins.
  - Both requesting with FIXED_PRIO=0: the master that is not last_grant wins, and last_grant updates to the winner.
- At the acceptance edge the winner's addr, we and wdata are latched. The requester must hold req, addr, we and wdata stable until it sees gnt.
- ACCESS cycle:
  - The winner's gnt is 1 for this cycle only.
  - mem_addr and mem_wdata carry the latched values.
  - mem_ena = latched we AND (addr < DEPTH).
  - All req inputs are ignored.
- End of ACCESS: for an in-range read, mem_rdata is captured into the winner's rdata.
- RESP cycle: the winner's rvalid is 1 for one cycle. mem_ena returns to 0.
- rdata behaviour:
  - rdata holds its value until the next read response to that master.
  - A write response leaves rdata unchanged.
- Latency and throughput:
  - rvalid is asserted 2 cycles after the acceptance edge.
  - Throughput is one transaction per 3 cycles.
- A master should drop req in the cycle gnt is seen. A req still high in the next IDLE is treated as a new request.
- Out-of-range access (addr >= DEPTH):
  - No memory write; mem_ena stays 0.
  - rvalid=1 and err=1 in RESP, with rdata forced to 0.
  - err is 0 on every in-range response.
- Address is used as a word index. Upper bits beyond clog2(DEPTH) matter only for the range check.
- Reset mid-transaction:
  - Aborts immediately; mem_ena drops asynchronously, so no partial write occurs after reset asserts.
  - No rvalid is issued for the aborted transaction.
- Never more than one gnt or one rvalid high in any cycle.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - master ID constants M0=0, M1=1;
  - DATA_W=32;
  - ADDR_W=32.
- One sub-module, rr_pick2: combinational 2-way picker taking req[1:0], last_grant and FIXED_PRIO, producing a winner ID and a valid flag.

Test Plan:
- Read: memory preloaded with mem[6]=45; m0 reads addr 6.
  - Required: m0_gnt high one cycle after the acceptance edge; m0_rvalid two cycles after; m0_rdata=45; m0_err=0.
- Write then read: m1 writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Required: mem_ena high exactly one cycle; read returns 0xDEADBEEF; m1_rdata is unchanged by the write response.
- Contention, round-robin: both masters request continuously with FIXED_PRIO=0.
  - Required: grants alternate M0, M1, M0, M1, each 3 cycles apart.
- Contention, fixed priority: same stimulus with FIXED_PRIO=1.
  - Required: M0 is granted every time.
- Out of range: m0 writes 0x12345678 to addr 1024.
  - Required: mem_ena stays 0; m0_rvalid=1, m0_err=1, m0_rdata=0; a later read of addr 0 returns the preloaded 0.
- Reset mid-op: assert rst low during the ACCESS cycle of a write to addr 2 with data 7.
  - Required: mem_ena drops to 0 immediately; mem[2] keeps 3; no rvalid; after release, the first tie grants M0.
